// File: rtl/tile_sched_pkg.sv
// Shared constants and FSM state encoding for the systolic-array tile scheduler.
package tile_sched_pkg;

   localparam int ARR_DEF   = 8;
   localparam int CNT_W_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WLOAD  = 3'd1,
      ST_SWITCH = 3'd2,
      ST_STREAM = 3'd3,
      ST_FLUSH  = 3'd4,
      ST_DRAIN  = 3'd5,
      ST_CLEAR  = 3'd6,
      ST_DONE   = 3'd7
   } state_e;

endpackage

// File: rtl/tile_sched_cycle_counter.sv
// Loadable down-counter; last flags the final unit so the owner can leave its state
// on the same cycle and the count never wraps below zero.
module cycle_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         last
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (en && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign last = (count_q == W'(1));

endmodule

// File: rtl/tile_sched.sv
// Tile scheduler: per weight tile runs load -> buffer swap -> ifmap stream -> skew flush
// -> accumulator drain -> clear, then signals job completion.
module tile_sched
   import tile_sched_pkg::*;
#(
   parameter int ARR   = ARR_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_tiles,
   input  logic [CNT_W-1:0] num_rows,
   input  logic             w_done,
   input  logic             if_valid,
   input  logic             acc_ready,
   output logic             w_load,
   output logic             switch,
   output logic             if_read,
   output logic             drain,
   output logic             clr_acc,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] tile_idx
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] tile_q, tile_d;
   logic [CNT_W-1:0] tiles_q, tiles_d;
   logic [CNT_W-1:0] rows_q, rows_d;

   logic row_ld, row_en, row_last;
   logic flush_ld, flush_en, flush_last;
   logic drain_ld, drain_en, drain_last;

   // if_read and drain follow their handshake inputs combinationally; the rest are Moore.
   assign w_load   = (state_q == ST_WLOAD);
   assign switch   = (state_q == ST_SWITCH);
   assign if_read  = (state_q == ST_STREAM) && if_valid;
   assign drain    = (state_q == ST_DRAIN) && acc_ready;
   assign clr_acc  = (state_q == ST_CLEAR);
   assign done     = (state_q == ST_DONE);
   assign busy     = (state_q != ST_IDLE);
   assign tile_idx = tile_q;

   always_comb begin
      state_d  = state_q;
      tile_d   = tile_q;
      tiles_d  = tiles_q;
      rows_d   = rows_q;
      row_ld   = 1'b0;
      row_en   = 1'b0;
      flush_ld = 1'b0;
      flush_en = 1'b0;
      drain_ld = 1'b0;
      drain_en = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               tiles_d = num_tiles;
               rows_d  = num_rows;
               tile_d  = '0;
               state_d = ((num_tiles != '0) && (num_rows != '0)) ? ST_WLOAD : ST_DONE;
            end
         end
         ST_WLOAD: begin
            if (w_done) state_d = ST_SWITCH;
         end
         ST_SWITCH: begin
            row_ld  = 1'b1;
            state_d = ST_STREAM;
         end
         ST_STREAM: begin
            row_en = if_read;
            if (if_read && row_last) begin
               flush_ld = 1'b1;
               state_d  = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            flush_en = 1'b1;
            if (flush_last) begin
               drain_ld = 1'b1;
               state_d  = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            drain_en = drain;
            if (drain && drain_last) state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            if (tile_q == tiles_q - CNT_W'(1)) begin
               state_d = ST_DONE;
            end else begin
               tile_d  = tile_q + CNT_W'(1);
               state_d = ST_WLOAD;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         tile_q  <= '0;
         tiles_q <= '0;
         rows_q  <= '0;
      end else begin
         state_q <= state_d;
         tile_q  <= tile_d;
         tiles_q <= tiles_d;
         rows_q  <= rows_d;
      end
   end

   cycle_counter #(.W(CNT_W)) u_row_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (row_ld),
      .load_val (rows_q),
      .en       (row_en),
      .last     (row_last)
   );

   // Flush covers the diagonal skew through the array: 2*ARR-1 cycles.
   cycle_counter #(.W(CNT_W)) u_flush_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (flush_ld),
      .load_val (CNT_W'(2 * ARR - 1)),
      .en       (flush_en),
      .last     (flush_last)
   );

   cycle_counter #(.W(CNT_W)) u_drain_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (drain_ld),
      .load_val (CNT_W'(ARR)),
      .en       (drain_en),
      .last     (drain_last)
   );

endmodule

// File: tb/tb_tile_sched.sv
// Directed bench for tile_sched: the driver pushes the expected per-cycle output vector
// for every busy cycle; a monitor pops and compares at each falling edge while busy.
module tb_tile_sched;

   localparam int ARR   = 4;
   localparam int CNT_W = 16;
   localparam int W     = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] num_tiles;
   logic [CNT_W-1:0] num_rows;
   logic             w_done;
   logic             if_valid;
   logic             acc_ready;
   logic             w_load;
   logic             switch;
   logic             if_read;
   logic             drain;
   logic             clr_acc;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] tile_idx;

   // {w_load, switch, if_read, drain, clr_acc, done, tile_idx[1:0]}
   logic [W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   tile_sched #(.ARR(ARR), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .num_tiles (num_tiles),
      .num_rows  (num_rows),
      .w_done    (w_done),
      .if_valid  (if_valid),
      .acc_ready (acc_ready),
      .w_load    (w_load),
      .switch    (switch),
      .if_read   (if_read),
      .drain     (drain),
      .clr_acc   (clr_acc),
      .busy      (busy),
      .done      (done),
      .tile_idx  (tile_idx)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] vec(input logic wl, input logic sw, input logic rd,
                                        input logic dr, input logic cl, input logic dn,
                                        input int t);
      logic [1:0] tt;
      tt = t[1:0];
      return {wl, sw, rd, dr, cl, dn, tt};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string name);
      check({name, "_busy"}, 32'(busy), 32'd0);
      check({name, "_outs"}, 32'({w_load, switch, if_read, drain, clr_acc, done}), 32'd0);
      check({name, "_tile"}, 32'(tile_idx), 32'd0);
   endtask

   // Monitor: every busy cycle must match the next expected vector.
   initial begin
      logic [W-1:0] got;
      logic [W-1:0] want;
      forever begin
         @(negedge clk);
         if (busy === 1'b1) begin
            got = {w_load, switch, if_read, drain, clr_acc, done, tile_idx[1:0]};
            if (exp_q.size() == 0) begin
               check("unexpected_busy", 32'(got), 32'hFFFF_FFFF);
            end else begin
               want = exp_q.pop_front();
               check("cycle_vec", 32'(got), 32'(want));
            end
         end
      end
   end

   // Drives one job and pushes the expected busy-cycle trace; counts are scrambled
   // after acceptance and side inputs are asserted where they must be ignored.
   task automatic run_job(input int tiles, input int rows, input int wl,
                          input logic [15:0] ifp, input logic [15:0] accp, input bit hold);
      int r;
      int d;
      int k;
      num_tiles = CNT_W'(tiles);
      num_rows  = CNT_W'(rows);
      start     = 1'b1;
      step();
      if (!hold) start = 1'b0;
      num_tiles = CNT_W'($urandom_range(0, 9));
      num_rows  = CNT_W'($urandom_range(0, 9));
      if (tiles == 0 || rows == 0) begin
         w_done = 1'b1; if_valid = 1'b1; acc_ready = 1'b1;
         exp_q.push_back(vec(0, 0, 0, 0, 0, 1, 0));
         step();
      end else begin
         for (int t = 0; t < tiles; t++) begin
            for (int i = 0; i < wl; i++) begin
               w_done = (i == wl - 1); if_valid = 1'b1; acc_ready = 1'b1;
               exp_q.push_back(vec(1, 0, 0, 0, 0, 0, t));
               step();
            end
            w_done = 1'b1;
            exp_q.push_back(vec(0, 1, 0, 0, 0, 0, t));
            step();
            r = rows; k = 0;
            while (r > 0) begin
               if_valid = ifp[k % 16]; acc_ready = 1'b1;
               exp_q.push_back(vec(0, 0, if_valid, 0, 0, 0, t));
               if (if_valid) r--;
               k++;
               step();
            end
            if_valid = 1'b1;
            for (int i = 0; i < 2 * ARR - 1; i++) begin
               exp_q.push_back(vec(0, 0, 0, 0, 0, 0, t));
               step();
            end
            d = ARR; k = 0;
            while (d > 0) begin
               acc_ready = accp[k % 16];
               exp_q.push_back(vec(0, 0, 0, acc_ready, 0, 0, t));
               if (acc_ready) d--;
               k++;
               step();
            end
            acc_ready = 1'b1;
            exp_q.push_back(vec(0, 0, 0, 0, 1, 0, t));
            step();
         end
         exp_q.push_back(vec(0, 0, 0, 0, 0, 1, tiles - 1));
         step();
      end
      start = 1'b0; w_done = 1'b0; if_valid = 1'b0; acc_ready = 1'b0;
      check("job_end_busy", 32'(busy), 32'd0);
      check("job_end_queue", 32'(exp_q.size()), 32'd0);
      step();
      check("job_stays_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; num_tiles = '0; num_rows = '0;
      w_done = 1'b0; if_valid = 1'b0; acc_ready = 1'b0;
      repeat (3) step();
      check_idle("reset");
      rst = 1'b1;

      run_job(1, 3, 3, 16'hFFFF, 16'hFFFF, 1'b0);
      run_job(3, 2, 2, 16'hFFFF, 16'hFFFF, 1'b0);
      run_job(1, 3, 1, 16'h5555, 16'hFFF3, 1'b0);
      run_job(2, 0, 1, 16'hFFFF, 16'hFFFF, 1'b0);
      run_job(0, 5, 1, 16'hFFFF, 16'hFFFF, 1'b0);

      // Reset in the middle of STREAM after two rows.
      num_tiles = CNT_W'(2); num_rows = CNT_W'(5); start = 1'b1;
      step();
      start = 1'b0; w_done = 1'b1;
      exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 0));
      step();
      w_done = 1'b0;
      exp_q.push_back(vec(0, 1, 0, 0, 0, 0, 0));
      step();
      if_valid = 1'b1;
      repeat (2) begin
         exp_q.push_back(vec(0, 0, 1, 0, 0, 0, 0));
         step();
      end
      if_valid = 1'b0; rst = 1'b0;
      exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0));
      step();
      rst = 1'b1;
      check_idle("mid_stream_reset");
      check("reset_queue", 32'(exp_q.size()), 32'd0);

      run_job(2, 2, 1, 16'hFFFF, 16'hFFFF, 1'b0);
      run_job(2, 2, 1, 16'hFFFF, 16'hFFFF, 1'b1);

      repeat (2) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
